// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
// Decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO. A multiply runs one
// shift-add step per cycle and a divide one restoring step per cycle. A
// FIX cycle then applies the sign correction and writes HI/LO. While an
// operation is in flight, any further mdu instruction is stalled.
//
// Handshake: an mdu instruction is consumed on a rising edge when it is
// presented (valid, RTYPE opcode, mdu funct) and stall is low. When stall
// is high, the instruction is not consumed and must be held until stall
// drops. The unit never aborts an accepted operation except on rst.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] F_MFHI   = 6'h10;
    localparam logic [5:0] F_MTHI   = 6'h11;
    localparam logic [5:0] F_MFLO   = 6'h12;
    localparam logic [5:0] F_MTLO   = 6'h13;
    localparam logic [5:0] F_MULT   = 6'h18;
    localparam logic [5:0] F_MULTU  = 6'h19;
    localparam logic [5:0] F_DIV    = 6'h1A;
    localparam logic [5:0] F_DIVU   = 6'h1B;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;       // multiply: {partial, multiplier}; divide: {remainder, quotient}
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic               sign_q;
    logic               sign_r;
    logic               div_zero;
    logic               op_div;

    logic               rtype, is_md, is_mf, is_mt, mdu_op, is_signed;
    logic [WIDTH-1:0]   rs_abs, rt_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   quo_fix, rem_fix, dz_hi;
    logic [2*WIDTH-1:0] prod_fix;

    // Instruction decode, stall and MFHI/MFLO read port.
    always_comb begin
        rtype        = valid && (opcode == OP_RTYPE);
        is_md        = rtype && ((funct == F_MULT) || (funct == F_MULTU) ||
                                 (funct == F_DIV)  || (funct == F_DIVU));
        is_mf        = rtype && ((funct == F_MFHI) || (funct == F_MFLO));
        is_mt        = rtype && ((funct == F_MTHI) || (funct == F_MTLO));
        mdu_op       = is_md || is_mf || is_mt;
        busy         = (state != S_IDLE);
        stall        = mdu_op && busy;
        result_valid = is_mf && !busy;
        result       = '0;
        if (result_valid) begin
            result = (funct == F_MFHI) ? hi : lo;
        end
        // funct bit 0 clear selects the signed variants (MULT, DIV)
        is_signed    = !funct[0];
        rs_abs       = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
        rt_abs       = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    end

    // One iteration step for each algorithm, plus the FIX-cycle sign correction.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        // the true difference is below the divisor whenever div_ge holds,
        // so the low WIDTH bits of the modular subtraction are exact
        div_rem   = div_shift[WIDTH-1:0] - opnd;
        prod_fix  = sign_q ? -acc : acc;
        quo_fix   = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        // divide-by-zero leaves |rs| untouched in the low half; restore its sign
        dz_hi     = sign_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end

    // Control FSM with the iteration datapath and the HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
            op_div   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_md) begin
                        count    <= CNT_INIT;
                        sign_q   <= is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        sign_r   <= is_signed && rs_val[WIDTH-1];
                        div_zero <= (rt_val == '0);
                        op_div   <= funct[1];
                        if (funct[1]) begin
                            acc   <= {{WIDTH{1'b0}}, rs_abs};
                            opnd  <= rt_abs;
                            state <= S_DIV;
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, rt_abs};
                            opnd  <= rs_abs;
                            state <= S_MUL;
                        end
                    end else if (is_mt) begin
                        if (funct == F_MTHI) hi <= rs_val;
                        else                 lo <= rs_val;
                    end
                end
                S_MUL: begin
                    acc   <= {mul_sum, acc[WIDTH-1:1]};
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE) state <= S_FIX;
                end
                S_DIV: begin
                    if (!div_zero) begin
                        acc <= {(div_ge ? div_rem : div_shift[WIDTH-1:0]),
                                acc[WIDTH-2:0], div_ge};
                    end
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE) state <= S_FIX;
                end
                S_FIX: begin
                    if (!op_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (div_zero) begin
                        hi <= dz_hi;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed and randomized operations against a
// plain-arithmetic reference model, on a WIDTH=32 and a WIDTH=8 instance.
module tb_muldiv_unit;

    localparam int W  = 32;
    localparam int W8 = 8;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          valid, stall, busy, result_valid;
    logic [5:0]    opcode, funct;
    logic [W-1:0]  rs_val, rt_val, result, hi, lo;

    logic          valid8, stall8, busy8, result_valid8;
    logic [5:0]    opcode8, funct8;
    logic [W8-1:0] rs8, rt8, result8, hi8, lo8;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .valid(valid), .opcode(opcode), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .busy(busy),
        .result(result), .result_valid(result_valid), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .valid(valid8), .opcode(opcode8), .funct(funct8),
        .rs_val(rs8), .rt_val(rt8), .stall(stall8), .busy(busy8),
        .result(result8), .result_valid(result_valid8), .hi(hi8), .lo(lo8)
    );

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];   // expected {hi, lo}, one entry per issued operation

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: {hi, lo} for a w-bit operation, from integer arithmetic.
    function automatic logic [63:0] model(input int w, input logic [5:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
        longint unsigned mask, ua, ub, p, hi_e, lo_e;
        longint sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'b0, a} & mask;
        ub   = {32'b0, b} & mask;
        sa   = ua[w-1] ? $signed(ua) - $signed(64'd1 << w) : $signed(ua);
        sb   = ub[w-1] ? $signed(ub) - $signed(64'd1 << w) : $signed(ub);
        hi_e = 0;
        lo_e = 0;
        case (f)
            F_MULT, F_MULTU: begin
                p    = (f == F_MULT) ? $unsigned(sa * sb) : ua * ub;
                hi_e = (p >> w) & mask;
                lo_e = p & mask;
            end
            default: begin
                if (ub == 0) begin
                    hi_e = ua;
                    lo_e = mask;
                end else if (f == F_DIV) begin
                    q    = sa / sb;
                    r    = sa % sb;
                    hi_e = $unsigned(r) & mask;
                    lo_e = $unsigned(q) & mask;
                end else begin
                    hi_e = (ua % ub) & mask;
                    lo_e = (ua / ub) & mask;
                end
            end
        endcase
        return {hi_e[31:0], lo_e[31:0]};
    endfunction

    // Issue one md op on the 32-bit unit (entered just after a negedge),
    // measure busy length, check HI/LO stay put until completion.
    task automatic run_md(input string tag, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        logic [31:0] hi0, lo0;
        int lat, early;
        exp_q.push_back(model(W, f, a, b));
        hi0 = hi;
        lo0 = lo;
        valid = 1'b1; opcode = 6'h00; funct = f; rs_val = a; rt_val = b;
        #1 check({tag, "_accept_stall"}, 64'(stall), 64'(0));
        @(posedge clk);
        #1;
        valid  = 1'b0;
        funct  = 6'($urandom);
        rs_val = $urandom;
        lat = 0;
        early = 0;
        @(negedge clk);
        while (busy === 1'b1 && lat < 100) begin
            lat++;
            if (hi !== hi0 || lo !== lo0) early++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        check({tag, "_latency"}, 64'(lat), 64'(W + 1));
        check({tag, "_hilo_early"}, 64'(early), 64'(0));
        check({tag, "_hilo"}, {hi, lo}, e);
    endtask

    task automatic run_md8(input string tag, input logic [5:0] f,
                           input logic [7:0] a, input logic [7:0] b);
        logic [63:0] e;
        int lat;
        e = model(W8, f, {24'b0, a}, {24'b0, b});
        valid8 = 1'b1; opcode8 = 6'h00; funct8 = f; rs8 = a; rt8 = b;
        @(posedge clk);
        #1 valid8 = 1'b0;
        lat = 0;
        @(negedge clk);
        while (busy8 === 1'b1 && lat < 100) begin
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency8"}, 64'(lat), 64'(W8 + 1));
        check({tag, "_hi8"}, 64'(hi8), 64'(e[39:32]));
        check({tag, "_lo8"}, 64'(lo8), 64'(e[7:0]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] e;
        logic [31:0] a, b;
        logic [5:0]  f;
        int lat, n_stall;

        rst = 1'b1;
        valid = 1'b0; opcode = 6'h00; funct = 6'h00; rs_val = '0; rt_val = '0;
        valid8 = 1'b0; opcode8 = 6'h00; funct8 = 6'h00; rs8 = '0; rt8 = '0;
        #12;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_stall", 64'(stall), 64'(0));
        check("reset_rv", 64'(result_valid), 64'(0));
        check("reset_result", 64'(result), 64'(0));
        check("reset_hilo", {hi, lo}, 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // directed multiply/divide cases, issued back to back
        run_md("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd5);
        run_md("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2);
        run_md("divu_zero", F_DIVU, 32'd100, 32'd0);
        run_md("div_zero_neg", F_DIV, 32'hFFFF_FF9C, 32'd0);
        run_md("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

        // MFLO held behind an in-flight MULT
        a = $urandom;
        b = $urandom;
        e = model(W, F_MULT, a, b);
        valid = 1'b1; opcode = 6'h00; funct = F_MULT; rs_val = a; rt_val = b;
        @(posedge clk);
        #1 funct = F_MFLO;
        lat = 0;
        n_stall = 0;
        @(negedge clk);
        while (busy === 1'b1 && lat < 100) begin
            lat++;
            if (stall === 1'b1 && result_valid === 1'b0) n_stall++;
            @(negedge clk);
        end
        check("mflo_wait_latency", 64'(lat), 64'(W + 1));
        check("mflo_stall_cycles", 64'(n_stall), 64'(W + 1));
        check("mflo_release_stall", 64'(stall), 64'(0));
        check("mflo_rv", 64'(result_valid), 64'(1));
        check("mflo_result", 64'(result), 64'(e[31:0]));
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);

        // MTHI/MFHI and MTLO/MFLO in idle
        valid = 1'b1; opcode = 6'h00; funct = F_MTHI; rs_val = 32'h1234_5678;
        #1 check("mthi_stall", 64'(stall), 64'(0));
        @(posedge clk);
        #1 funct = F_MFHI; rs_val = $urandom;
        @(negedge clk);
        check("mfhi_result", 64'(result), 64'h1234_5678);
        check("mfhi_rv", 64'(result_valid), 64'(1));
        check("mfhi_stall", 64'(stall), 64'(0));
        a = $urandom;
        funct = F_MTLO; rs_val = a;
        @(posedge clk);
        #1 funct = F_MFLO;
        @(negedge clk);
        check("mflo_idle_result", 64'(result), 64'(a));
        check("mtlo_hi_kept", 64'(hi), 64'h1234_5678);

        // non-RTYPE opcode: no start, no read port
        opcode = 6'h01; funct = F_MULT; rs_val = 32'd7; rt_val = 32'd9;
        #1 check("nonr_stall", 64'(stall), 64'(0));
        @(posedge clk);
        #1 check("nonr_busy", 64'(busy), 64'(0));
        funct = F_MFHI;
        #1 check("nonr_rv", 64'(result_valid), 64'(0));
        valid = 1'b0;
        opcode = 6'h00;
        funct = F_MULT;
        @(posedge clk);
        #1 check("invalid_busy", 64'(busy), 64'(0));
        @(negedge clk);

        // reset during a divide
        valid = 1'b1; funct = F_DIV; rs_val = 32'hDEAD_BEEF; rt_val = 32'd13;
        @(posedge clk);
        #1 funct = F_MFHI;
        repeat (10) @(posedge clk);
        #2 check("pre_rst_stall", 64'(stall), 64'(1));
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_stall", 64'(stall), 64'(0));
        check("midrst_hilo", {hi, lo}, 64'(0));
        check("midrst_result", 64'(result), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        valid = 1'b0;
        run_md("multu_after_rst", F_MULTU, 32'd2, 32'd3);

        // randomized operations
        for (int i = 0; i < 24; i++) begin
            f = 6'(F_MULT + 6'($urandom_range(0, 3)));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                3: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: ;
            endcase
            run_md($sformatf("rand%0d", i), f, a, b);
        end

        // 8-bit instance
        run_md8("w8_mult_neg", F_MULT, 8'hFD, 8'h05);
        run_md8("w8_div_ovf", F_DIV, 8'h80, 8'hFF);
        run_md8("w8_divu_zero", F_DIVU, 8'd100, 8'd0);
        run_md8("w8_div_neg", F_DIV, 8'hF9, 8'h02);
        for (int i = 0; i < 8; i++) begin
            run_md8($sformatf("w8_rand%0d", i), 6'(F_MULT + 6'($urandom_range(0, 3))),
                    8'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. Sits beside the ALU in the execute stage: decodes the R-type funct codes the ALU decoder does not handle (MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO), runs a one-bit-per-cycle shift-add multiply or restoring divide, and raises a stall to the pipeline controller while a result is pending.

## Interface
- WIDTH, 32, operand/HI/LO width; even, >= 4
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- valid  in  1  instruction in execute stage is live (not bubbled or flushed)
- opcode  in  6  instruction bits [31:26]; unit acts only when equal to `RTYPE (6'h00)
- funct  in  6  instruction bits [5:0]: `MFHI 6'h10, `MTHI 6'h11, `MFLO 6'h12, `MTLO 6'h13, `MULT 6'h18, `MULTU 6'h19, `DIV 6'h1A, `DIVU 6'h1B
- rs_val  in  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source)
- rt_val  in  WIDTH  rt operand (multiplier/divisor)
- stall  out  1  hold execute stage this cycle
- busy  out  1  operation in flight
- result  out  WIDTH  MFHI/MFLO read data
- result_valid  out  1  result is an MFHI/MFLO value this cycle
- hi, lo  out  WIDTH  architectural HI/LO, registered

## Operation
- "md_op" = valid & opcode==`RTYPE & funct in {MULT, MULTU, DIV, DIVU}; "mdu_op" = md_op or MFHI/MFLO/MTHI/MTLO. Any other instruction ignored: stall=0, no state change.
- States: IDLE, MUL, DIV, FIX.
- IDLE: md_op accepted at edge → capture |rs|, |rt| (signed ops) or raw (unsigned), record sign_q = rs[W-1]^rt[W-1], sign_r = rs[W-1]; counter = WIDTH; go MUL or DIV.
- MUL: shift-add on 2*WIDTH accumulator, one multiplier bit per cycle; counter decrements; at 0 go FIX.
- DIV: restoring divide, one quotient bit per cycle, WIDTH-bit remainder plus one carry bit; at 0 go FIX.
- FIX: apply two's-complement negation where signs require (product by sign_q; quotient by sign_q, remainder by sign_r); write HI/LO; go IDLE.
- Multiply: {HI,LO} = 2*WIDTH-bit product, HI upper half.
- Divide: LO = quotient, HI = remainder, truncation toward zero; remainder takes dividend's sign.
- Divide by zero (rt_val==0, any divide): no iteration-dependent result; HI = original rs_val, LO = all ones. Latency unchanged.
- Signed most-negative / -1: LO = 1 followed by WIDTH-1 zeros, HI = 0, no trap.
- MTHI/MTLO in IDLE: HI/LO <= rs_val at that edge.
- MFHI/MFLO in IDLE: result = hi/lo combinationally, result_valid=1, same cycle.
- Any mdu_op while busy: stall=1, instruction not consumed, result_valid=0; retried by holding inputs.
- valid dropping while busy (flush) does not abort the in-flight operation.

## Timing
- Reset (async, immediate): state IDLE, busy=0, stall=0, result_valid=0, hi=0, lo=0, result=0, counter=0. Reset mid-operation aborts; HI/LO read 0.
- md_op accepted at edge E: busy=1 from E through E+WIDTH+1; HI/LO updated at edge E+WIDTH+1; busy=0 after that edge. Total latency WIDTH+1 cycles (33 for WIDTH=32).
- The accepting cycle itself: stall=0 (op consumed); pipeline proceeds.
- Back-to-back: an mdu_op presented in the cycle busy falls is accepted (no bubble); a new md_op issued then starts immediately.
- stall is combinational from valid/opcode/funct and registered busy; no path from result to stall.
- Counter width = $clog2(WIDTH+1).

## Test plan
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF → busy 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
- MULT rs=-3 (0xFFFFFFFD) rt=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV rs=-7 rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=100 rt=0 → HI=0x00000064, LO=0xFFFFFFFF after 33 cycles; DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MFLO issued one cycle after MULT accept → stall=1 for remaining busy cycles, then result=LO product with result_valid=1 in cycle busy=0.
- MTHI 0x12345678 then MFHI in IDLE → result=0x12345678 with no stall; non-RTYPE opcode with funct=6'h18 → no start, stall=0.
- Assert rst mid-DIV (cycle 10) → busy, stall, hi, lo all 0 immediately; following MULTU 2*3 → LO=6, HI=0. Repeat MULT case with WIDTH=8: latency 9 cycles.
